// File: rtl/spike_rate_decoder_if.sv
// Spike decoder bus: enable/spike stream in, rate and ISI estimates out.
interface spike_rate_decoder_if #(
  parameter int unsigned ISI_W = 16
);
  logic             en_i;
  logic             spike_i;
  logic [7:0]       rate_o;
  logic             rate_valid_o;
  logic [ISI_W-1:0] isi_o;
  logic             isi_valid_o;
  logic             overflow_o;

  modport master (
    output en_i, spike_i,
    input  rate_o, rate_valid_o, isi_o, isi_valid_o, overflow_o
  );

  modport slave (
    input  en_i, spike_i,
    output rate_o, rate_valid_o, isi_o, isi_valid_o, overflow_o
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: windowed spike-rate estimate plus inter-spike interval.
// Optional EMA smoothing of the rate is enabled by defining SPIKE_DECODER_EMA_EN.
module spike_rate_decoder #(
  parameter int unsigned WINDOW_CYCLES = 256,
  parameter int unsigned ISI_W         = 16,
  parameter int unsigned EMA_SHIFT     = 2
) (
  input logic                 clk_i,
  input logic                 rst_n,
  spike_rate_decoder_if.slave bus
);

  localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES);
  localparam int unsigned CNT_W = 9;
  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  if (WINDOW_CYCLES < 2 || EMA_SHIFT < 1 || EMA_SHIFT > 7) begin : g_param_check
    $error("spike_rate_decoder: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_RUN
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic               spike_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [CNT_W-1:0]   spike_cnt_q;
  logic [ISI_W-1:0]   isi_cnt_q;
  logic [7:0]         rate_q;
  logic               rate_valid_q;
  logic [ISI_W-1:0]   isi_q;
  logic               isi_valid_q;
  logic               overflow_q;

  logic               event_c;
  logic               win_last_c;
  logic               sat_c;
  logic [CNT_W-1:0]   count_c;
  logic [7:0]         new_rate_c;
  logic [7:0]         rate_next_c;

  // State register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enable low always parks in IDLE; the enabling cycle acts as FIRST
  always_comb begin
    state_d = state_q;
    if (!bus.en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = event_c ? ST_RUN : ST_FIRST;
        ST_FIRST: state_d = event_c ? ST_RUN : ST_FIRST;
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Edge detect and window-close rate value
  always_comb begin
    event_c    = bus.spike_i & ~spike_q;
    win_last_c = (win_cnt_q == WIN_W'(WINDOW_CYCLES - 1));
    sat_c      = (spike_cnt_q >= CNT_W'(255));
    count_c    = spike_cnt_q + CNT_W'(event_c);
    new_rate_c = sat_c ? 8'hFF : count_c[7:0];
  end

`ifdef SPIKE_DECODER_EMA_EN
  logic              first_win_q;
  logic signed [8:0] ema_diff_c;
  logic signed [8:0] ema_step_c;
  logic signed [9:0] ema_sum_c;

  // Smoothed rate: old + (new - old) >>> EMA_SHIFT, clamped to 0..255
  always_comb begin
    ema_diff_c = $signed({1'b0, new_rate_c}) - $signed({1'b0, rate_q});
    ema_step_c = ema_diff_c >>> EMA_SHIFT;
    ema_sum_c  = $signed({2'b00, rate_q}) + $signed({ema_step_c[8], ema_step_c});
    if (first_win_q) begin
      rate_next_c = new_rate_c;
    end else if (ema_sum_c[9]) begin
      rate_next_c = 8'd0;
    end else if (ema_sum_c[8]) begin
      rate_next_c = 8'hFF;
    end else begin
      rate_next_c = ema_sum_c[7:0];
    end
  end

  // First window after leaving IDLE loads the raw count
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      first_win_q <= 1'b1;
    end else if (!bus.en_i) begin
      first_win_q <= 1'b1;
    end else if (win_last_c) begin
      first_win_q <= 1'b0;
    end
  end
`else
  always_comb begin
    rate_next_c = new_rate_c;
  end
`endif

  // Window, spike and ISI counters with registered outputs
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      spike_q      <= 1'b0;
      win_cnt_q    <= '0;
      spike_cnt_q  <= '0;
      isi_cnt_q    <= '0;
      rate_q       <= '0;
      rate_valid_q <= 1'b0;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      spike_q      <= bus.spike_i;
      rate_valid_q <= 1'b0;
      isi_valid_q  <= 1'b0;
      if (!bus.en_i) begin
        win_cnt_q   <= '0;
        spike_cnt_q <= '0;
        isi_cnt_q   <= '0;
        overflow_q  <= 1'b0;
      end else begin
        win_cnt_q <= win_last_c ? '0 : win_cnt_q + WIN_W'(1);

        if (event_c && sat_c) begin
          overflow_q <= 1'b1;
        end

        // A boundary-cycle event is folded into the closing window via count_c
        if (win_last_c) begin
          spike_cnt_q  <= '0;
          rate_q       <= rate_next_c;
          rate_valid_q <= 1'b1;
        end else if (event_c && !sat_c) begin
          spike_cnt_q <= spike_cnt_q + CNT_W'(1);
        end

        if (event_c) begin
          isi_cnt_q <= ISI_W'(1);
          if (state_q == ST_RUN) begin
            isi_q       <= isi_cnt_q;
            isi_valid_q <= 1'b1;
          end
        end else if (state_q == ST_RUN && isi_cnt_q != ISI_MAX) begin
          isi_cnt_q <= isi_cnt_q + ISI_W'(1);
        end
      end
    end
  end

  assign bus.rate_o       = rate_q;
  assign bus.rate_valid_o = rate_valid_q;
  assign bus.isi_o        = isi_q;
  assign bus.isi_valid_o  = isi_valid_q;
  assign bus.overflow_o   = overflow_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: two configurations driven by one stimulus stream,
// checked every cycle against a behavioural model plus literal anchor values.
module tb_spike_rate_decoder;

  localparam int unsigned W_A   = 256;
  localparam int unsigned ISI_A = 16;
  localparam int unsigned W_B   = 1024;
  localparam int unsigned ISI_B = 4;
  localparam int ISI_MAX_A = (1 << ISI_A) - 1;
  localparam int ISI_MAX_B = (1 << ISI_B) - 1;
  localparam int SHIFT = 2;
`ifdef SPIKE_DECODER_EMA_EN
  localparam bit EMA = 1'b1;
`else
  localparam bit EMA = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic spike = 1'b0;
  bit   chk_on = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  spike_rate_decoder_if #(.ISI_W(ISI_A)) bus_a ();
  spike_rate_decoder_if #(.ISI_W(ISI_B)) bus_b ();

  assign bus_a.en_i    = en;
  assign bus_a.spike_i = spike;
  assign bus_b.en_i    = en;
  assign bus_b.spike_i = spike;

  spike_rate_decoder #(.WINDOW_CYCLES(W_A), .ISI_W(ISI_A), .EMA_SHIFT(SHIFT)) dut_a (
    .clk_i(clk), .rst_n(rst_n), .bus(bus_a)
  );
  spike_rate_decoder #(.WINDOW_CYCLES(W_B), .ISI_W(ISI_B), .EMA_SHIFT(SHIFT)) dut_b (
    .clk_i(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // Model: timestamps of edges, session start time and raw per-window edge count
  typedef struct {
    logic prev;
    bit   active;
    bit   seen;
    bit   first_win;
    int   t;
    int   t_start;
    int   ncnt;
    int   last_edge;
    int   rate;
    int   isi;
    bit   rv;
    bit   iv;
    bit   ov;
  } mdl_t;

  mdl_t ma;
  mdl_t mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.prev = 1'b0; m.active = 1'b0; m.seen = 1'b0; m.first_win = 1'b1;
    m.t = 0; m.t_start = 0; m.ncnt = 0; m.last_edge = 0;
    m.rate = 0; m.isi = 0; m.rv = 1'b0; m.iv = 1'b0; m.ov = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input logic e, input logic s,
                                    input int win, input int isi_max);
    bit ed;
    int nw;
    ed = (s == 1'b1) && (m.prev == 1'b0);
    m.prev = s;
    m.rv = 1'b0;
    m.iv = 1'b0;
    m.t++;
    if (e != 1'b1) begin
      m.active = 1'b0; m.seen = 1'b0; m.ncnt = 0; m.ov = 1'b0; m.first_win = 1'b1;
      return m;
    end
    if (!m.active) begin
      m.active = 1'b1;
      m.t_start = m.t;
    end
    if (ed) begin
      m.ncnt++;
      if (m.ncnt > 255) m.ov = 1'b1;
      if (m.seen) begin
        m.isi = (m.t - m.last_edge > isi_max) ? isi_max : m.t - m.last_edge;
        m.iv = 1'b1;
      end
      m.seen = 1'b1;
      m.last_edge = m.t;
    end
    if ((m.t - m.t_start) % win == win - 1) begin
      nw = (m.ncnt > 255) ? 255 : m.ncnt;
      if (EMA && !m.first_win) begin
        m.rate = m.rate + ((nw - m.rate) >>> SHIFT);
        if (m.rate < 0) m.rate = 0;
        if (m.rate > 255) m.rate = 255;
      end else begin
        m.rate = nw;
      end
      m.first_win = 1'b0;
      m.rv = 1'b1;
      m.ncnt = 0;
    end
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma = mdl_reset();
      mb = mdl_reset();
    end else begin
      ma = mdl_step(ma, en, spike, int'(W_A), ISI_MAX_A);
      mb = mdl_step(mb, en, spike, int'(W_B), ISI_MAX_B);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model, away from the clock edges
  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      check("A.rate",      32'(bus_a.rate_o),       32'(ma.rate));
      check("A.rate_vld",  32'(bus_a.rate_valid_o), 32'(ma.rv));
      check("A.isi",       32'(bus_a.isi_o),        32'(ma.isi));
      check("A.isi_vld",   32'(bus_a.isi_valid_o),  32'(ma.iv));
      check("A.overflow",  32'(bus_a.overflow_o),   32'(ma.ov));
      check("B.rate",      32'(bus_b.rate_o),       32'(mb.rate));
      check("B.rate_vld",  32'(bus_b.rate_valid_o), 32'(mb.rv));
      check("B.isi",       32'(bus_b.isi_o),        32'(mb.isi));
      check("B.isi_vld",   32'(bus_b.isi_valid_o),  32'(mb.iv));
      check("B.overflow",  32'(bus_b.overflow_o),   32'(mb.ov));
    end
  end

  task automatic drive(input logic e, input logic s);
    en = e;
    spike = s;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst.A.rate", 32'(bus_a.rate_o), 32'd0);
    check("rst.A.isi", 32'(bus_a.isi_o), 32'd0);
    check("rst.A.ovf", 32'(bus_a.overflow_o), 32'd0);
    check("rst.B.rate_vld", 32'(bus_b.rate_valid_o), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Periodic pulses every 4 cycles
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, (i % 4) == 0);
      if (i == 255) begin
        check("t1.A.rate", 32'(bus_a.rate_o), 32'd64);
        check("t1.A.rate_vld", 32'(bus_a.rate_valid_o), 32'd1);
      end
    end
    check("t1.A.isi", 32'(bus_a.isi_o), 32'd4);
    idle(3);

    // Window boundary ownership
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, i == 255);
      if (i == 255) check("t4.last.A.rate", 32'(bus_a.rate_o), 32'd1);
    end
    idle(3);
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, i == 256);
      if (i == 255) check("t4.first.w0.A.rate", 32'(bus_a.rate_o), 32'd0);
      if (i == 511) check("t4.first.w1.A.rate", 32'(bus_a.rate_o), EMA ? 32'd0 : 32'd1);
    end
    idle(3);

    // Held level counts once; long ISI
    for (int i = 0; i < 400; i++) begin
      drive(1'b1, (i < 100) || (i == 300));
      if (i == 255) check("t2.A.rate", 32'(bus_a.rate_o), 32'd1);
    end
    check("t2.A.isi", 32'(bus_a.isi_o), 32'd300);
    check("t2.B.isi_sat", 32'(bus_b.isi_o), 32'd15);
    idle(3);

    // Toggle every cycle: saturation in the long window
    for (int i = 0; i < 1030; i++) begin
      drive(1'b1, (i % 2) == 0);
      if (i == 255) check("t3.A.rate", 32'(bus_a.rate_o), 32'd128);
      if (i == 1023) begin
        check("t3.B.rate", 32'(bus_b.rate_o), 32'd255);
        check("t3.B.ovf", 32'(bus_b.overflow_o), 32'd1);
      end
    end
    drive(1'b0, 1'b0);
    check("t3.B.ovf_clr", 32'(bus_b.overflow_o), 32'd0);
    idle(2);

    // Mid-window reset after ten spikes
    for (int i = 0; i < 400; i++) drive(1'b1, (i % 40) == 0);
    rst_n = 1'b0;
    #1;
    check("t5.rst.A.rate", 32'(bus_a.rate_o), 32'd0);
    check("t5.rst.A.isi", 32'(bus_a.isi_o), 32'd0);
    check("t5.rst.B.rate", 32'(bus_b.rate_o), 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, (i % 40) == 5);
      if (i == 255) check("t5.A.rate_post", 32'(bus_a.rate_o), 32'd7);
    end
    check("t5.A.isi", 32'(bus_a.isi_o), 32'd40);
    check("t5.B.isi_sat", 32'(bus_b.isi_o), 32'd15);
    idle(3);

    // Rate step 64 -> 0 (smoothed or raw)
    for (int i = 0; i < 512; i++) begin
      drive(1'b1, (i < 256) && ((i % 4) == 0));
      if (i == 255) check("t6.A.rate_w0", 32'(bus_a.rate_o), 32'd64);
      if (i == 511) check("t6.A.rate_w1", 32'(bus_a.rate_o), EMA ? 32'd48 : 32'd0);
    end
    idle(3);

    // Randomized spike trains with occasional enable drops
    for (int blk = 0; blk < 12; blk++) begin
      int dens;
      dens = int'($urandom_range(1, 7));
      for (int i = 0; i < 260; i++) begin
        drive($urandom_range(0, 149) != 0, $urandom_range(0, 7) < dens);
      end
    end

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
